// File: rtl/sc_point_pkg.sv
// Shared definitions for the point FSM and the point register:
// shift command codes and the EMPTY/LOADED state encoding.
package sc_point_pkg;

  localparam logic [1:0] SHIFT_HOLD = 2'b11;
  localparam logic [1:0] SHIFT_UP   = 2'b01;
  localparam logic [1:0] SHIFT_DOWN = 2'b10;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

endpackage

// File: rtl/sc_onehot_encoder.sv
// One-hot to binary index encoder; yields 0 for an all-zero input.
module sc_onehot_encoder #(
  parameter int WIDTH = 8,
  parameter int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_onehot,
  output logic [POS_W-1:0] o_index
);

  // OR of the indices of set bits is exact as long as the input is one-hot.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i_onehot[i]) o_index = o_index | POS_W'(i);
  end

endmodule

// File: rtl/sc_point_register.sv
// One-hot point register executing load/shift commands from the point FSM
// and reporting legal moves through active-low comparator flags.
module sc_point_register
  import sc_point_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POINT_INIT = 8'b0001_0000,
  parameter int               CNT_W      = 8,
  localparam int              POS_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             SC_POINTREGISTER_CLOCK_50,
  input  logic             SC_POINTREGISTER_RESET_InHigh,
  input  logic             SC_POINTREGISTER_load_InLow,
  input  logic [1:0]       SC_POINTREGISTER_shiftselection_In,
  output logic [WIDTH-1:0] SC_POINTREGISTER_data_Out,
  output logic             SC_POINTREGISTER_Comparador_moveLEFT_OutLow,
  output logic             SC_POINTREGISTER_Comparador_moveRIGHT_OutLow,
  output logic [POS_W-1:0] SC_POINTREGISTER_position_Out,
  output logic [CNT_W-1:0] SC_POINTREGISTER_moveCount_Out,
  output logic             SC_POINTREGISTER_moved_Out,
  output logic             SC_POINTREGISTER_error_Out
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_moved;
  logic             r_err;

  logic             w_loaded;
  logic             w_can_up;
  logic             w_can_down;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_loaded   = (r_state == ST_LOADED);
  assign w_can_up   = w_loaded & ~r_data[WIDTH-1];
  assign w_can_down = w_loaded & ~r_data[0];
  assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge SC_POINTREGISTER_CLOCK_50 or posedge SC_POINTREGISTER_RESET_InHigh) begin
    if (SC_POINTREGISTER_RESET_InHigh) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
      r_moved <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      // Load outranks any shift code presented in the same cycle.
      if (!SC_POINTREGISTER_load_InLow) begin
        r_state <= ST_LOADED;
        r_data  <= POINT_INIT;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end else if (w_loaded) begin
        case (SC_POINTREGISTER_shiftselection_In)
          SHIFT_UP: begin
            if (w_can_up) begin
              r_data  <= r_data << 1;
              r_cnt   <= w_cnt_inc;
              r_moved <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          SHIFT_DOWN: begin
            if (w_can_down) begin
              r_data  <= r_data >> 1;
              r_cnt   <= w_cnt_inc;
              r_moved <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sc_onehot_encoder #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_enc (
    .i_onehot (r_data),
    .o_index  (SC_POINTREGISTER_position_Out)
  );

  assign SC_POINTREGISTER_data_Out                    = r_data;
  assign SC_POINTREGISTER_Comparador_moveLEFT_OutLow  = ~w_can_up;
  assign SC_POINTREGISTER_Comparador_moveRIGHT_OutLow = ~w_can_down;
  assign SC_POINTREGISTER_moveCount_Out               = r_cnt;
  assign SC_POINTREGISTER_moved_Out                   = r_moved;
  assign SC_POINTREGISTER_error_Out                   = r_err;

endmodule

// File: tb/tb_sc_point_register.sv
// Bench for sc_point_register: directed scenarios plus random commands,
// checked against a position-based model (two DUTs: CNT_W=8 and CNT_W=2).
module tb_sc_point_register;

  localparam int W        = 8;
  localparam int INIT_POS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_n = 1'b1;
  logic [1:0] sh = 2'b11;

  logic [W-1:0] a_data, b_data;
  logic         a_fl, a_fr, b_fl, b_fr;
  logic [2:0]   a_pos, b_pos;
  logic [7:0]   a_cnt;
  logic [1:0]   b_cnt;
  logic         a_mv, a_err, b_mv, b_err;

  int checks = 0;
  int errors = 0;

  // reference model: point as an index, count as plain saturating integers
  bit m_loaded;
  int m_pos, m_cnt8, m_cnt2;
  bit m_moved, m_err;

  always #5 clk = ~clk;

  sc_point_register #(.WIDTH(W), .POINT_INIT(8'b0001_0000), .CNT_W(8)) dut_a (
    .SC_POINTREGISTER_CLOCK_50                    (clk),
    .SC_POINTREGISTER_RESET_InHigh                (rst),
    .SC_POINTREGISTER_load_InLow                  (ld_n),
    .SC_POINTREGISTER_shiftselection_In           (sh),
    .SC_POINTREGISTER_data_Out                    (a_data),
    .SC_POINTREGISTER_Comparador_moveLEFT_OutLow  (a_fl),
    .SC_POINTREGISTER_Comparador_moveRIGHT_OutLow (a_fr),
    .SC_POINTREGISTER_position_Out                (a_pos),
    .SC_POINTREGISTER_moveCount_Out               (a_cnt),
    .SC_POINTREGISTER_moved_Out                   (a_mv),
    .SC_POINTREGISTER_error_Out                   (a_err)
  );

  sc_point_register #(.WIDTH(W), .POINT_INIT(8'b0001_0000), .CNT_W(2)) dut_b (
    .SC_POINTREGISTER_CLOCK_50                    (clk),
    .SC_POINTREGISTER_RESET_InHigh                (rst),
    .SC_POINTREGISTER_load_InLow                  (ld_n),
    .SC_POINTREGISTER_shiftselection_In           (sh),
    .SC_POINTREGISTER_data_Out                    (b_data),
    .SC_POINTREGISTER_Comparador_moveLEFT_OutLow  (b_fl),
    .SC_POINTREGISTER_Comparador_moveRIGHT_OutLow (b_fr),
    .SC_POINTREGISTER_position_Out                (b_pos),
    .SC_POINTREGISTER_moveCount_Out               (b_cnt),
    .SC_POINTREGISTER_moved_Out                   (b_mv),
    .SC_POINTREGISTER_error_Out                   (b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_pos = 0; m_cnt8 = 0; m_cnt2 = 0; m_moved = 0; m_err = 0;
  endtask

  task automatic model_step(input bit l_n, input logic [1:0] s);
    m_moved = 0;
    if (!l_n) begin
      m_loaded = 1; m_pos = INIT_POS; m_cnt8 = 0; m_cnt2 = 0; m_err = 0;
    end else if (m_loaded && (s == 2'b01 || s == 2'b10)) begin
      if ((s == 2'b01 && m_pos == W-1) || (s == 2'b10 && m_pos == 0)) begin
        m_err = 1;
      end else begin
        m_pos  = (s == 2'b01) ? m_pos + 1 : m_pos - 1;
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        m_moved = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e_data;
    e_data = m_loaded ? W'(1 << m_pos) : '0;
    chk("data",  32'(a_data), 32'(e_data));
    chk("left",  32'(a_fl),   32'(!(m_loaded && m_pos != W-1)));
    chk("right", 32'(a_fr),   32'(!(m_loaded && m_pos != 0)));
    chk("pos",   32'(a_pos),  32'(m_loaded ? m_pos : 0));
    chk("cnt8",  32'(a_cnt),  32'(m_cnt8));
    chk("moved", 32'(a_mv),   32'(m_moved));
    chk("err",   32'(a_err),  32'(m_err));
    chk("b_data", 32'(b_data), 32'(e_data));
    chk("b_pos",  32'(b_pos),  32'(m_loaded ? m_pos : 0));
    chk("cnt2",   32'(b_cnt),  32'(m_cnt2));
    chk("b_moved", 32'(b_mv),  32'(m_moved));
    chk("b_err",  32'(b_err),  32'(m_err));
    chk("b_flags", 32'({b_fl, b_fr}), 32'({a_fl, a_fr}));
  endtask

  // Drive a command for one cycle; outputs sampled 1 time unit after the edge.
  task automatic cyc(input bit l_n, input logic [1:0] s);
    ld_n = l_n; sh = s;
    @(posedge clk);
    model_step(l_n, s);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // empty: hold, then a shift that must be ignored without error
    repeat (5) cyc(1, 2'b11);
    cyc(1, 2'b01);
    chk("empty_err", 32'(a_err), 32'd0);

    // load, single up-shift
    cyc(0, 2'b11);
    chk("init_data", 32'(a_data), 32'h10);
    cyc(1, 2'b01);
    chk("up_data", 32'(a_data), 32'h20);
    chk("up_moved", 32'(a_mv), 32'd1);
    cyc(1, 2'b11);
    chk("moved_drop", 32'(a_mv), 32'd0);

    // walk to the MSB, then an illegal up-shift
    cyc(0, 2'b11);
    repeat (3) begin cyc(1, 2'b01); cyc(1, 2'b11); end
    chk("msb_data", 32'(a_data), 32'h80);
    chk("msb_flags", 32'({a_fl, a_fr}), 32'b10);
    cyc(1, 2'b01);
    chk("msb_err", 32'(a_err), 32'd1);
    chk("msb_cnt", 32'(a_cnt), 32'd3);

    // load beats a simultaneous down-shift and clears error
    cyc(0, 2'b10);
    chk("ldsh_data", 32'(a_data), 32'h10);
    chk("ldsh_err", 32'(a_err), 32'd0);
    chk("ldsh_mv", 32'(a_mv), 32'd0);

    // down held for 6 cycles: 4 shifts then error
    repeat (6) cyc(1, 2'b10);
    chk("lsb_data", 32'(a_data), 32'h01);
    chk("lsb_cnt", 32'(a_cnt), 32'd4);
    chk("lsb_err", 32'(a_err), 32'd1);

    // mid-sequence reset
    cyc(0, 2'b11);
    cyc(1, 2'b10);
    mid_reset();
    chk("rst_data", 32'(a_data), 32'd0);

    // saturation of the 2-bit counter
    cyc(0, 2'b11);
    repeat (5) begin cyc(1, 2'b01); cyc(1, 2'b10); end
    chk("sat2", 32'(b_cnt), 32'd3);
    chk("cnt8_10", 32'(a_cnt), 32'd10);

    // random commands with occasional load and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) mid_reset();
      cyc($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
